core_id_scoreboard: RTL and testbench
=====================================

# core_id_scoreboard

Register-hazard scoreboard and issue controller placed between the ID stage and the execute stage. It takes the decoded register fields produced by instruction decode and tracks which architectural registers have a write in flight. It holds the ID→EX handshake while an instruction reads or rewrites a pending register, and releases it when writeback retires that register. Flush support and a stall-cycle counter are included.

## Interface
Parameters:
- `RFIDX_W`, default 5: register index width (`CORE_RFIDX_WIDTH`).
- `NREG`, default 32: number of architectural registers; equals 2^`RFIDX_W`.
- `CNT_W`, default 32: width of the stall-cycle counter.

Ports (reset is synchronous and active-low):
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `valid_in`  in  1  ID stage holds a decoded instruction.
- `ready_in`  out  1  scoreboard accepts that instruction this cycle.
- `valid_out`  out  1  instruction issues to EX.
- `ready_out`  in  1  EX can accept an instruction.
- `i_rs1_ren`, `i_rs2_ren`, `i_rd_wen`  in  1 each  read and write enables from decode.
- `i_rs1_idx`, `i_rs2_idx`, `i_rd_idx`  in  `RFIDX_W` each  register indices.
- `i_wb_valid`  in  1  a writeback retires a register this cycle.
- `i_wb_idx`  in  `RFIDX_W`  register being retired.
- `i_flush`  in  1  pipeline flush; discards all pending state.
- `o_hazard`  out  1  current instruction is blocked by a dependency.
- `o_pending`  out  `NREG`  pending-write bit vector; bit 0 is always 0.
- `o_pend_cnt`  out  `RFIDX_W`+1  population count of `o_pending`.
- `o_stall_cnt`  out  `CNT_W`  saturating count of hazard-stall cycles.

## Operation
Effective pending vector:
- `eff = pending & ~(i_wb_valid ? onehot(i_wb_idx) : 0)`.
- A register retired in the same cycle does not cause a stall (writeback bypass).

Hazard:
- `o_hazard = valid_in & ((i_rs1_ren & eff[i_rs1_idx]) | (i_rs2_ren & eff[i_rs2_idx]) | (i_rd_wen & eff[i_rd_idx]))`.
- This covers RAW on rs1/rs2 and WAW on rd.
- Index 0 never hazards.

Handshake, all combinational:
- `valid_out = valid_in & ~o_hazard & ~i_flush`.
- `ready_in = ready_out & ~o_hazard & ~i_flush`.
- Issue occurs when `valid_out & ready_out`.

Pending-vector update at each clock edge, in priority order:
1. `!rst_n` or `i_flush`: pending ← 0.
2. Otherwise, clear: if `i_wb_valid`, clear bit `i_wb_idx`.
3. Set: if issue & `i_rd_wen` & `i_rd_idx != 0`, set bit `i_rd_idx`.
4. If clear and set target the same register in one cycle, set wins; the new write is outstanding.

Other rules:
- A writeback to a non-pending register, or to index 0, is ignored. No error is raised.
- `o_pend_cnt` is the popcount of the registered pending vector, not of `eff`.

Stall counter:
- Increments by 1 each cycle that `valid_in & o_hazard & ~i_flush`.
- Saturates at all-ones.
- Cleared only by reset; flush does not clear it.

## Timing
- Reset values:
  - `pending` = 0, so `o_pending` = 0 and `o_pend_cnt` = 0.
  - `o_stall_cnt` = 0.
  - `o_hazard`, `valid_out` and `ready_in` follow the combinational rules. With pending = 0, `valid_out = valid_in & ~i_flush`.
- Hazard decision and handshake outputs have zero-cycle latency from the ID inputs.
- A pending bit set by an issue in cycle N is visible from cycle N+1. A dependent instruction presented in N+1 stalls.
- A writeback in cycle M unblocks a dependent instruction in cycle M itself, through the bypass.
- Flush in cycle F:
  - No issue in F.
  - Pending = 0 from F+1.
  - The flush overrides a simultaneous issue or writeback.
- `ready_out = 0` with no hazard: `valid_out` stays high and the instruction is held upstream. Pending is unchanged and the stall counter does not increment.
- Reset asserted mid-operation: all pending state is cleared at that edge, and outstanding writebacks that arrive later are ignored.

## Test plan
- Independent stream: issue rd=5, then an instruction reading rs1=6, both with `ready_out`=1 → no stall; `o_pending` = 0x20 after the first edge; `o_pend_cnt` = 1.
- RAW stall: issue rd=5; next cycle rs1=5 with `valid_in`=1 → `o_hazard`=1, `valid_out`=0, `ready_in`=0 for 3 cycles; `o_stall_cnt` = 3. Apply `i_wb_valid` with idx 5 → issues in the same cycle; `o_pending` = 0 afterwards.
- WAW plus simultaneous retire: pending {7}. Present rd=7 together with wb idx=7 → issues; `o_pending` bit 7 is still 1 after the edge (set wins).
- x0 handling: issue rd=0 with `i_rd_wen`=1, then read rs1=0 → `o_pending` stays 0 and no hazard is raised.
- Flush: pending {3,9,12}, stalled instruction reading 9; assert `i_flush` for 1 cycle → `valid_out`=0 that cycle; `o_pending`=0 and `o_pend_cnt`=0 next cycle; the instruction then issues.
- Reset: mid-stall with `o_stall_cnt`=10, drive `rst_n`=0 for 1 edge → `o_stall_cnt`=0 and `o_pending`=0; a later wb idx=3 is ignored.

Source files
------------

// File: rtl/core_id_scoreboard.sv
// Register-hazard scoreboard between ID and EX: tracks in-flight register writes,
// holds the ID->EX handshake on RAW/WAW dependencies and counts stall cycles.

module core_id_sb_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic clr,
  input  logic set,
  output logic pend
);
  logic pend_d, pend_q;

  // Set beats clear: a write issued in the same cycle its predecessor retires stays outstanding.
  always_comb begin
    pend_d = pend_q;
    if (flush)    pend_d = 1'b0;
    else if (set) pend_d = 1'b1;
    else if (clr) pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end

  assign pend = pend_q;
endmodule

module core_id_scoreboard #(
  parameter int RFIDX_W = 5,
  parameter int NREG    = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  output logic               ready_in,
  output logic               valid_out,
  input  logic               ready_out,
  input  logic               i_rs1_ren,
  input  logic               i_rs2_ren,
  input  logic               i_rd_wen,
  input  logic [RFIDX_W-1:0] i_rs1_idx,
  input  logic [RFIDX_W-1:0] i_rs2_idx,
  input  logic [RFIDX_W-1:0] i_rd_idx,
  input  logic               i_wb_valid,
  input  logic [RFIDX_W-1:0] i_wb_idx,
  input  logic               i_flush,
  output logic               o_hazard,
  output logic [NREG-1:0]    o_pending,
  output logic [RFIDX_W:0]   o_pend_cnt,
  output logic [CNT_W-1:0]   o_stall_cnt
);
  typedef struct packed {
    logic               rs1_ren;
    logic               rs2_ren;
    logic               rd_wen;
    logic [RFIDX_W-1:0] rs1_idx;
    logic [RFIDX_W-1:0] rs2_idx;
    logic [RFIDX_W-1:0] rd_idx;
  } dec_req_t;

  dec_req_t         req;
  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  wb_clr;
  logic [NREG-1:0]  rd_set;
  logic [NREG-1:0]  eff;
  logic             hazard;
  logic             issue;
  logic [RFIDX_W:0] pend_cnt;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  assign req = '{rs1_ren: i_rs1_ren, rs2_ren: i_rs2_ren, rd_wen: i_rd_wen,
                 rs1_idx: i_rs1_idx, rs2_idx: i_rs2_idx, rd_idx: i_rd_idx};

  // Same-cycle writeback is bypassed so the dependent instruction issues immediately.
  assign wb_clr = i_wb_valid ? (NREG'(1) << i_wb_idx) : '0;
  assign eff    = pending & ~wb_clr;

  assign hazard = valid_in & ((req.rs1_ren & eff[req.rs1_idx]) |
                              (req.rs2_ren & eff[req.rs2_idx]) |
                              (req.rd_wen  & eff[req.rd_idx]));

  assign valid_out = valid_in & ~hazard & ~i_flush;
  assign ready_in  = ready_out & ~hazard & ~i_flush;
  assign issue     = valid_out & ready_out;

  assign rd_set = (issue & req.rd_wen) ? (NREG'(1) << req.rd_idx) : '0;

  // x0 is hardwired: never pending, so it can never hazard.
  assign pending[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NREG; r++) begin : g_reg
      core_id_sb_cell u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (i_flush),
        .clr   (wb_clr[r]),
        .set   (rd_set[r]),
        .pend  (pending[r])
      );
    end
  endgenerate

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < NREG; i++) pend_cnt = pend_cnt + (RFIDX_W+1)'(pending[i]);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard & ~i_flush & (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign o_hazard    = hazard;
  assign o_pending   = pending;
  assign o_pend_cnt  = pend_cnt;
  assign o_stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_core_id_scoreboard.sv
// Directed, table-driven bench for core_id_scoreboard plus hand-written flush/reset sequences.
`timescale 1ns/1ps
module tb_core_id_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, ready_out;
  logic        rs1_ren, rs2_ren, rd_wen;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic        wb_valid, flush;
  logic [4:0]  wb_idx;
  logic        ready_in, valid_out, hazard;
  logic [31:0] pending;
  logic [5:0]  pend_cnt;
  logic [31:0] stall_cnt;
  // small-counter instance to observe saturation
  logic        s_ready_in, s_valid_out, s_hazard;
  logic [31:0] s_pending;
  logic [5:0]  s_pend_cnt;
  logic [2:0]  s_stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  core_id_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
    .valid_out(valid_out), .ready_out(ready_out),
    .i_rs1_ren(rs1_ren), .i_rs2_ren(rs2_ren), .i_rd_wen(rd_wen),
    .i_rs1_idx(rs1_idx), .i_rs2_idx(rs2_idx), .i_rd_idx(rd_idx),
    .i_wb_valid(wb_valid), .i_wb_idx(wb_idx), .i_flush(flush),
    .o_hazard(hazard), .o_pending(pending), .o_pend_cnt(pend_cnt), .o_stall_cnt(stall_cnt));

  core_id_scoreboard #(.CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(s_ready_in),
    .valid_out(s_valid_out), .ready_out(ready_out),
    .i_rs1_ren(rs1_ren), .i_rs2_ren(rs2_ren), .i_rd_wen(rd_wen),
    .i_rs1_idx(rs1_idx), .i_rs2_idx(rs2_idx), .i_rd_idx(rd_idx),
    .i_wb_valid(wb_valid), .i_wb_idx(wb_idx), .i_flush(flush),
    .o_hazard(s_hazard), .o_pending(s_pending), .o_pend_cnt(s_pend_cnt), .o_stall_cnt(s_stall_cnt));

  typedef struct {
    logic v, r1r, r2r, rdw, ro, wbv, fl;
    logic [4:0] r1, r2, rd, wbi;
    logic e_haz, e_vo, e_ri;
    logic [31:0] e_pend;
    int e_cnt, e_stall;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r1r, input logic [4:0] r1,
                       input logic r2r, input logic [4:0] r2, input logic rdw, input logic [4:0] rd,
                       input logic ro, input logic wbv, input logic [4:0] wbi, input logic fl);
    valid_in = v; rs1_ren = r1r; rs1_idx = r1; rs2_ren = r2r; rs2_idx = r2;
    rd_wen = rdw; rd_idx = rd; ready_out = ro; wb_valid = wbv; wb_idx = wbi; flush = fl;
  endtask

  function automatic vec_t mk(input logic v, r1r, input logic [4:0] r1, input logic r2r,
                              input logic [4:0] r2, input logic rdw, input logic [4:0] rd,
                              input logic ro, wbv, input logic [4:0] wbi,
                              input logic eh, evo, eri, input logic [31:0] ep, input int ec, es);
    vec_t t;
    t.v = v; t.r1r = r1r; t.r1 = r1; t.r2r = r2r; t.r2 = r2; t.rdw = rdw; t.rd = rd;
    t.ro = ro; t.wbv = wbv; t.wbi = wbi; t.fl = 1'b0;
    t.e_haz = eh; t.e_vo = evo; t.e_ri = eri; t.e_pend = ep; t.e_cnt = ec; t.e_stall = es;
    return t;
  endfunction

  task automatic chk_io(input string tag, input logic eh, input logic evo, input logic eri);
    chk({tag, ".hazard"},    32'(hazard),    32'(eh));
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(evo));
    chk({tag, ".ready_in"},  32'(ready_in),  32'(eri));
  endtask

  task automatic chk_st(input string tag, input logic [31:0] ep, input int ec, input int es);
    chk({tag, ".pending"},   pending,         ep);
    chk({tag, ".pend_cnt"},  32'(pend_cnt),   32'(ec));
    chk({tag, ".stall_cnt"}, stall_cnt,       32'(es));
    chk({tag, ".stall_sat"}, 32'(s_stall_cnt), (es > 7) ? 32'd7 : 32'(es));
  endtask

  initial begin
    //            v r1r r1 r2r r2 rdw rd ro wbv wbi   haz vo ri  pend          cnt stall
    tbl[0]  = mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0,      0, 1, 1, 32'h0,        0, 0);
    tbl[1]  = mk(1, 1, 6, 0, 0, 0, 0, 1, 0, 0,      0, 1, 1, 32'h20,       1, 0);
    tbl[2]  = mk(1, 1, 5, 0, 0, 0, 0, 1, 0, 0,      1, 0, 0, 32'h20,       1, 0);
    tbl[3]  = mk(1, 1, 5, 0, 0, 0, 0, 1, 0, 0,      1, 0, 0, 32'h20,       1, 1);
    tbl[4]  = mk(1, 1, 5, 0, 0, 0, 0, 1, 0, 0,      1, 0, 0, 32'h20,       1, 2);
    tbl[5]  = mk(1, 1, 5, 0, 0, 0, 0, 1, 1, 5,      0, 1, 1, 32'h20,       1, 3);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,      0, 0, 1, 32'h0,        0, 3);
    tbl[7]  = mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0,      0, 1, 1, 32'h0,        0, 3);
    tbl[8]  = mk(1, 1, 0, 0, 0, 1, 7, 1, 0, 0,      0, 1, 1, 32'h0,        0, 3);
    tbl[9]  = mk(1, 0, 0, 0, 0, 1, 7, 1, 1, 7,      0, 1, 1, 32'h80,       1, 3);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,      0, 0, 1, 32'h80,       1, 3);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7,      0, 0, 1, 32'h80,       1, 3);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,      0, 0, 1, 32'h0,        0, 3);
    tbl[13] = mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 0,      0, 1, 0, 32'h0,        0, 3);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,      0, 0, 1, 32'h0,        0, 3);
    tbl[15] = mk(1, 0, 0, 0, 0, 1, 9, 1, 0, 0,      0, 1, 1, 32'h0,        0, 3);
    tbl[16] = mk(1, 0, 0, 1, 9, 0, 0, 1, 0, 0,      1, 0, 0, 32'h200,      1, 3);
    tbl[17] = mk(1, 0, 0, 0, 9, 0, 0, 1, 0, 0,      0, 1, 1, 32'h200,      1, 4);
    tbl[18] = mk(1, 0, 0, 0, 0, 1, 9, 1, 0, 0,      1, 0, 0, 32'h200,      1, 4);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 9,      0, 0, 1, 32'h200,      1, 5);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,      0, 0, 1, 32'h0,        0, 5);

    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    chk_io("reset", 0, 1, 1);
    chk_st("reset", 32'h0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].r1r, tbl[i].r1, tbl[i].r2r, tbl[i].r2, tbl[i].rdw, tbl[i].rd,
            tbl[i].ro, tbl[i].wbv, tbl[i].wbi, tbl[i].fl);
      #2;
      chk_io($sformatf("vec%0d", i), tbl[i].e_haz, tbl[i].e_vo, tbl[i].e_ri);
      chk_st($sformatf("vec%0d", i), tbl[i].e_pend, tbl[i].e_cnt, tbl[i].e_stall);
    end

    // Flush: pending {3,9,12}, instruction reading x9 stalls, flush clears everything.
    @(negedge clk); drive(1, 0, 0, 0, 0, 1, 3,  1, 0, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 1, 9,  1, 0, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0);
    @(negedge clk); drive(1, 1, 9, 0, 0, 0, 0, 1, 0, 0, 0); #2;
    chk_io("fl_stall", 1, 0, 0);
    chk_st("fl_stall", 32'h1208, 3, 5);
    @(negedge clk); drive(1, 1, 9, 0, 0, 0, 0, 1, 1, 12, 1); #2;
    chk_io("fl_cycle", 1, 0, 0);
    chk_st("fl_cycle", 32'h1208, 3, 6);
    @(negedge clk); drive(1, 1, 9, 0, 0, 0, 0, 1, 0, 0, 0); #2;
    chk_io("fl_after", 0, 1, 1);
    chk_st("fl_after", 32'h0, 0, 6);

    // Reset mid-stall with the counter at 10; a late writeback must be ignored.
    @(negedge clk); drive(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
    repeat (4) begin
      @(negedge clk); drive(1, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0);
    end
    @(negedge clk); #2;
    chk_io("rst_pre", 1, 0, 0);
    chk_st("rst_pre", 32'h8, 1, 10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0); #2;
    chk_st("rst_post", 32'h0, 0, 0);
    @(negedge clk); drive(1, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0); #2;
    chk_io("rst_wb_ign", 0, 1, 1);
    chk_st("rst_wb_ign", 32'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
